partition_err_meter: RTL

Exhaustive error-measurement stage placed directly downstream of an 8-input/4-output synthesized partition in the approximate-logic flow. It sweeps every input pattern into the exact partition and its approximated counterpart, and samples both output words on each pattern. It accumulates error rate, total Hamming distance and maximum absolute error. The result is a cycle-accurate hardware replacement for the exhaustive print-and-diff testbench flow used when scoring a partition approximation.

---
 rtl/partition_err_meter_if.sv | 28 ++
 rtl/partition_err_meter.sv | 97 +++++++++
 2 files changed

// File: rtl/partition_err_meter_if.sv
// partition_err_meter_if: sweep control, partition stimulus/response and error results bundle (PARTITION_ERR_FIRST_EN adds first-error capture)
interface partition_err_meter_if #(
  parameter int PI_W = 8,
  parameter int PO_W = 4
);
  logic start;
  logic [PI_W-1:0] pi_out;
  logic [PO_W-1:0] po_exact;
  logic [PO_W-1:0] po_approx;
  logic busy;
  logic done;
  logic [PI_W:0] err_cnt;
  logic [PI_W+$clog2(PO_W):0] hd_sum;
  logic [PO_W-1:0] max_err;
`ifdef PARTITION_ERR_FIRST_EN
  logic [PI_W-1:0] first_err_pi;
  logic first_err_vld;
  modport master (output start, po_exact, po_approx,
                  input pi_out, busy, done, err_cnt, hd_sum, max_err, first_err_pi, first_err_vld);
  modport slave (input start, po_exact, po_approx,
                 output pi_out, busy, done, err_cnt, hd_sum, max_err, first_err_pi, first_err_vld);
`else
  modport master (output start, po_exact, po_approx,
                  input pi_out, busy, done, err_cnt, hd_sum, max_err);
  modport slave (input start, po_exact, po_approx,
                 output pi_out, busy, done, err_cnt, hd_sum, max_err);
`endif
endinterface

// File: rtl/partition_err_meter.sv
// partition_err_meter: exhaustive exact-vs-approximate partition error sweep (PARTITION_ERR_FIRST_EN adds first-error capture)
module partition_err_meter #(
  parameter int PI_W = 8,
  parameter int PO_W = 4
) (
  input logic clk,
  input logic rst_n,
  partition_err_meter_if.slave bus
);
  localparam int HD_W = PI_W + $clog2(PO_W) + 1;
  localparam logic [PI_W:0] LAST = (PI_W+1)'(2**PI_W - 1);
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
  state_t state;
  logic [PI_W:0] cnt;
  logic s_valid;
  logic [PO_W-1:0] s_exact, s_approx;
`ifdef PARTITION_ERR_FIRST_EN
  logic [PI_W-1:0] s_pi;
`endif
  logic [PO_W-1:0] x, mag;
  logic [PO_W:0] diff, neg;
  logic [HD_W-1:0] pc;
  assign bus.pi_out = cnt[PI_W-1:0];
  // error metrics of the registered sample: xor, popcount and unsigned magnitude
  always_comb begin
    x = s_exact ^ s_approx;
    diff = {1'b0, s_exact} - {1'b0, s_approx};
    neg = -diff;
    mag = diff[PO_W] ? neg[PO_W-1:0] : diff[PO_W-1:0];
    pc = '0;
    for (int i = 0; i < PO_W; i++) pc = pc + HD_W'(x[i]);
  end
  // sweep FSM, sample stage and accumulators; a start clear overrides accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      s_valid <= 1'b0;
      s_exact <= '0;
      s_approx <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.err_cnt <= '0;
      bus.hd_sum <= '0;
      bus.max_err <= '0;
`ifdef PARTITION_ERR_FIRST_EN
      s_pi <= '0;
      bus.first_err_pi <= '0;
      bus.first_err_vld <= 1'b0;
`endif
    end else begin
      if (s_valid) begin
        bus.err_cnt <= bus.err_cnt + (PI_W+1)'(|x);
        bus.hd_sum <= bus.hd_sum + pc;
        if (mag > bus.max_err) bus.max_err <= mag;
`ifdef PARTITION_ERR_FIRST_EN
        if (|x && !bus.first_err_vld) begin
          bus.first_err_pi <= s_pi;
          bus.first_err_vld <= 1'b1;
        end
`endif
      end
      case (state)
        IDLE, DONE: if (bus.start) begin
          state <= SWEEP;
          cnt <= '0;
          s_valid <= 1'b0;
          bus.busy <= 1'b1;
          bus.done <= 1'b0;
          bus.err_cnt <= '0;
          bus.hd_sum <= '0;
          bus.max_err <= '0;
`ifdef PARTITION_ERR_FIRST_EN
          bus.first_err_pi <= '0;
          bus.first_err_vld <= 1'b0;
`endif
        end
        SWEEP: begin
          s_valid <= 1'b1;
          s_exact <= bus.po_exact;
          s_approx <= bus.po_approx;
`ifdef PARTITION_ERR_FIRST_EN
          s_pi <= cnt[PI_W-1:0];
`endif
          if (cnt == LAST) state <= DRAIN;
          else cnt <= cnt + 1'b1;
        end
        default: begin
          s_valid <= 1'b0;
          state <= DONE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end
      endcase
    end
  end
endmodule
